// File: rtl/handshake_pkg.sv
// handshake_pkg: shared widths, table access and reset constants for handshake units
package handshake_pkg;

    localparam int unsigned TBL_MAX_W = 1024;
    localparam logic        DATA_RST  = 1'b0;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Entry i of a packed table, returned right-aligned; caller truncates to w bits
    function automatic logic [TBL_MAX_W-1:0] tbl_entry(
        input logic [TBL_MAX_W-1:0] tbl,
        input int unsigned          i,
        input int unsigned          w
    );
        return (tbl >> (i * w)) & ((TBL_MAX_W'(1) << w) - TBL_MAX_W'(1));
    endfunction

endpackage

// File: rtl/handshake_skid_buf2.sv
// handshake_skid_buf2: 2-entry skid buffer, registered ready, 1 token/cycle
module handshake_skid_buf2
    import handshake_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [DATA_WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic                  main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic                  accept, consume;

    assign in_ready  = !rst && !skid_valid_q;
    assign accept    = in_valid && in_ready;
    assign consume   = main_valid_q && out_ready;
    assign out_data  = main_data_q;
    assign out_valid = main_valid_q;

    always_comb begin
        main_data_d  = main_data_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (!main_valid_q) begin
            main_data_d  = accept ? in_data : main_data_q;
            main_valid_d = accept;
        end else if (consume) begin
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            // in_ready guarantees the skid slot is free here
            skid_data_d  = in_data;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_data_q  <= {DATA_WIDTH{DATA_RST}};
            skid_data_q  <= {DATA_WIDTH{DATA_RST}};
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

endmodule

// File: rtl/handshake_constant_seq.sv
// handshake_constant_seq: emits successive constant-table entries per accepted control token
module handshake_constant_seq
    import handshake_pkg::*;
#(
    parameter int unsigned                   DATA_WIDTH  = 32,
    parameter int unsigned                   DEPTH       = 4,
    parameter logic [DEPTH*DATA_WIDTH-1:0]   CONST_TABLE = 128'h00000008_00000007_00000006_00000005,
    parameter bit                            WRAP        = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int unsigned          IW      = idx_width(DEPTH);
    localparam logic [TBL_MAX_W-1:0] TBL_EXT = TBL_MAX_W'(CONST_TABLE);

    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] entry;
    logic                  accept, last;

    assign accept = ctrl_valid && ctrl_ready;
    assign last   = idx_q == IW'(DEPTH - 1);
    assign entry  = DATA_WIDTH'(tbl_entry(TBL_EXT, int'(idx_q), DATA_WIDTH));

    always_comb begin
        idx_d = idx_q;
        if (accept)
            idx_d = last ? (WRAP ? '0 : idx_q) : idx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) idx_q <= '0;
        else     idx_q <= idx_d;
    end

    handshake_skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_data   (entry),
        .in_valid  (ctrl_valid),
        .in_ready  (ctrl_ready),
        .out_data  (outs),
        .out_valid (outs_valid),
        .out_ready (outs_ready)
    );

endmodule

// File: tb/tb_handshake_constant_seq.sv
// tb_handshake_constant_seq: directed checks of wrap, saturate, backpressure, reset and DEPTH=1
module tb_handshake_constant_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_cv = 1'b0, w_or = 1'b0, w_cr, w_ov;
    logic [31:0] w_outs;
    logic        s_cv = 1'b0, s_or = 1'b0, s_cr, s_ov;
    logic [31:0] s_outs;
    logic        d_cv = 1'b0, d_or = 1'b0, d_cr, d_ov;
    logic [3:0]  d_outs;

    int tests = 0;
    int failed = 0;
    int n_in = 0;
    int n_out = 0;

    always #5 clk = ~clk;

    handshake_constant_seq u_wrap (
        .clk(clk), .rst(rst), .ctrl_valid(w_cv), .ctrl_ready(w_cr),
        .outs(w_outs), .outs_valid(w_ov), .outs_ready(w_or)
    );

    handshake_constant_seq #(.WRAP(1'b0)) u_sat (
        .clk(clk), .rst(rst), .ctrl_valid(s_cv), .ctrl_ready(s_cr),
        .outs(s_outs), .outs_valid(s_ov), .outs_ready(s_or)
    );

    handshake_constant_seq #(.DATA_WIDTH(4), .DEPTH(1), .CONST_TABLE(4'h5)) u_d1 (
        .clk(clk), .rst(rst), .ctrl_valid(d_cv), .ctrl_ready(d_cr),
        .outs(d_outs), .outs_valid(d_ov), .outs_ready(d_or)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_wrap [6] = '{5, 6, 7, 8, 5, 6};
        logic [31:0] exp_sat  [6] = '{5, 6, 7, 8, 8, 8};
        logic [31:0] exp_sim  [4] = '{5, 6, 7, 8};
        logic        r;

        // 1: reset, then continuous stream with wrap
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ctrl_ready", w_cr, 0);
            chk("rst_outs_valid", w_ov, 0);
            chk("rst_outs", w_outs, 0);
        end
        rst = 1'b0; w_cv = 1'b1; w_or = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("wrap_valid", w_ov, 1);
            chk("wrap_outs", w_outs, exp_wrap[i]);
        end
        w_cv = 1'b0;
        tick();
        chk("wrap_drain", w_ov, 0);

        // 2: saturation
        s_cv = 1'b1; s_or = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("sat_valid", s_ov, 1);
            chk("sat_outs", s_outs, exp_sat[i]);
        end
        s_cv = 1'b0;
        tick();
        chk("sat_drain", s_ov, 0);

        // 3: backpressure
        rst = 1'b1;
        tick();
        rst = 1'b0; w_cv = 1'b1; w_or = 1'b0;
        tick();
        chk("bp_first", w_outs, 5);
        chk("bp_ready1", w_cr, 1);
        tick();
        chk("bp_full_ready", w_cr, 0);
        chk("bp_hold1", w_outs, 5);
        tick();
        chk("bp_stall_ready", w_cr, 0);
        chk("bp_hold2", w_outs, 5);
        chk("bp_hold_valid", w_ov, 1);
        w_or = 1'b1;
        tick();
        chk("bp_second", w_outs, 6);
        chk("bp_ready_back", w_cr, 1);
        tick();
        chk("bp_third", w_outs, 7);
        w_cv = 1'b0;
        tick();
        chk("bp_empty", w_ov, 0);

        // 4: simultaneous accept + consume, idx resumes at entry 3
        w_cv = 1'b1;
        tick();
        chk("sim_fill", w_outs, 8);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sim_outs", w_outs, exp_sim[i]);
            chk("sim_valid", w_ov, 1);
            chk("sim_skid_empty", w_cr, 1);
        end
        w_cv = 1'b0;
        tick();
        chk("sim_drain", w_ov, 0);

        // 5: reset mid-stream
        w_cv = 1'b1; w_or = 1'b0;
        tick();
        tick();
        chk("mid_full", w_cr, 0);
        rst = 1'b1; w_cv = 1'b0;
        tick();
        chk("mid_rst_valid", w_ov, 0);
        chk("mid_rst_outs", w_outs, 0);
        chk("mid_rst_ready", w_cr, 0);
        rst = 1'b0;
        tick();
        chk("mid_ready", w_cr, 1);
        chk("mid_valid", w_ov, 0);
        w_cv = 1'b1;
        tick();
        chk("mid_first", w_outs, 5);
        w_cv = 1'b0; w_or = 1'b1;
        tick();
        chk("mid_drain", w_ov, 0);

        // 6: DEPTH=1 randomised traffic
        for (int i = 0; i < 200; i++) begin
            d_cv = 1'($urandom_range(0, 1));
            d_or = 1'($urandom_range(0, 1));
            #2;
            r = d_cr;
            d_or = ~d_or;
            #1;
            chk("d1_ready_comb", d_cr, r);
            d_or = ~d_or;
            #1;
            if (d_ov) chk("d1_outs", d_outs, 4'b0101);
            if (d_cv && d_cr) n_in++;
            if (d_ov && d_or) n_out++;
            tick();
        end
        d_cv = 1'b0; d_or = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            if (d_ov && d_or) n_out++;
            tick();
        end
        chk("d1_count", n_out, n_in);
        chk("d1_empty", d_ov, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
